// File: rtl/u14_pkg.sv
// u14_pkg: opcode nibbles, addressing modes, NOP/JMP opcodes and FSM state
// encoding shared by the u14 core.
// Build option: U14_ABS_EN enables absolute addressing and JMP abs.
package u14_pkg;

  // High nibble of the opcode selects the operation
  localparam logic [3:0] NIB_ORA = 4'h0;
  localparam logic [3:0] NIB_AND = 4'h2;
  localparam logic [3:0] NIB_EOR = 4'h4;
  localparam logic [3:0] NIB_ADC = 4'h6;
  localparam logic [3:0] NIB_STA = 4'h8;
  localparam logic [3:0] NIB_LDA = 4'hA;
  localparam logic [3:0] NIB_SBC = 4'hE;

  // Low nibble of the opcode selects the addressing mode
  localparam logic [3:0] MODE_IMM = 4'h9;
  localparam logic [3:0] MODE_ZP  = 4'h5;
  localparam logic [3:0] MODE_ABS = 4'hD;

  localparam logic [7:0] OPC_NOP = 8'hEA;
  localparam logic [7:0] OPC_JMP = 8'h4C;

  // FSM state encoding
  localparam logic [1:0] ST_FETCH  = 2'd0;
  localparam logic [1:0] ST_DECODE = 2'd1;
  localparam logic [1:0] ST_OPHI   = 2'd2;
  localparam logic [1:0] ST_MEM    = 2'd3;

`ifdef U14_ABS_EN
  localparam bit ABS_EN = 1'b1;
`else
  localparam bit ABS_EN = 1'b0;
`endif

  // Instruction classes after decode; AM_NONE covers every 1-byte NOP
  typedef enum logic [2:0] {
    AM_NONE,
    AM_IMM,
    AM_ZP,
    AM_ABS,
    AM_JMP
  } amode_e;

  function automatic logic is_op_nib(input logic [3:0] nib);
    return (nib == NIB_ORA) || (nib == NIB_AND) || (nib == NIB_EOR) ||
           (nib == NIB_ADC) || (nib == NIB_STA) || (nib == NIB_LDA) ||
           (nib == NIB_SBC);
  endfunction

  // Classify an opcode byte; STA immediate and undefined codes fall to NOP
  function automatic amode_e decode_mode(input logic [7:0] opc);
    amode_e m;
    m = AM_NONE;
    if (is_op_nib(opc[7:4])) begin
      if (opc[3:0] == MODE_IMM && opc[7:4] != NIB_STA) m = AM_IMM;
      else if (opc[3:0] == MODE_ZP)                     m = AM_ZP;
      else if (opc[3:0] == MODE_ABS && ABS_EN)          m = AM_ABS;
    end
    if (opc == OPC_JMP && ABS_EN) m = AM_JMP;
    if (opc == OPC_NOP)           m = AM_NONE;
    return m;
  endfunction

endpackage

// File: rtl/u14_alu.sv
// u14_alu: combinational accumulator ALU for the u14 core.
// ADC/SBC update carry; bitwise ops and LDA pass carry through.
// Zero flag reflects the result of every operation.
module u14_alu
  import u14_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [3:0]    op,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] m,
  input  logic          cin,
  output logic [DW-1:0] y,
  output logic          cout,
  output logic          z
);

  logic [DW:0] sum;

  // Operation select; SBC is add-with-carry of the inverted operand
  always_comb begin
    sum  = '0;
    y    = a;
    cout = cin;
    case (op)
      NIB_ORA: y = a | m;
      NIB_AND: y = a & m;
      NIB_EOR: y = a ^ m;
      NIB_LDA: y = m;
      NIB_ADC: begin
        sum  = {1'b0, a} + {1'b0, m} + {{DW{1'b0}}, cin};
        y    = sum[DW-1:0];
        cout = sum[DW];
      end
      NIB_SBC: begin
        sum  = {1'b0, a} + {1'b0, ~m} + {{DW{1'b0}}, cin};
        y    = sum[DW-1:0];
        cout = sum[DW];
      end
      default: y = a;
    endcase
  end

  assign z = (y == '0);

endmodule

// File: rtl/u14_cpu.sv
// u14_cpu: minimal accumulator CPU with a combinational-read memory bus.
// Build option: define U14_ABS_EN for absolute addressing and JMP abs;
// without it the OPHI state is not built and those opcodes are NOPs.
//
//   state  | meaning
//   FETCH  | latch opcode, step pc; NOP-class opcodes stay here
//   DECODE | immediate execute, or form zero-page / low address byte
//   OPHI   | high address byte: JMP target or absolute operand address
//   MEM    | operand read or store of A, then return addr to pc
module u14_cpu
  import u14_pkg::*;
#(
  parameter int            DW       = 8,
  parameter int            AW       = 16,
  parameter logic [AW-1:0] RST_ADDR = 'hFFF0
) (
  input  logic          clk,
  input  logic          rst,
  inout  wire  [DW-1:0] data,
  output logic [AW-1:0] addr,
  output logic          rw,
  output logic          sync,
  output logic [DW-1:0] acc,
  output logic [1:0]    flags
);

  logic [1:0]    state;
  logic [AW-1:0] pc;
  logic [AW-1:0] pc_inc;
  logic [7:0]    instr;
  logic          c_flag;
  logic          z_flag;
  amode_e        mode_f;
  amode_e        mode_i;
  logic          is_sta;
  logic          alu_we;
  logic [DW-1:0] alu_y;
  logic          alu_c;
  logic          alu_z;

`ifdef U14_ABS_EN
  logic [7:0]    lo_byte;
  logic [AW-1:0] target;
  assign target = AW'({data[7:0], lo_byte});
`endif

  assign pc_inc = pc + AW'(1);
  assign mode_f = decode_mode(data[7:0]);
  assign mode_i = decode_mode(instr);
  assign is_sta = (instr[7:4] == NIB_STA);
  assign sync   = (state == ST_FETCH);
  assign flags  = {c_flag, z_flag};

  // The core drives the bus only during its own store cycle
  assign data = rw ? acc : {DW{1'bz}};

  u14_alu #(.DW(DW)) u_alu (
    .op   (instr[7:4]),
    .a    (acc),
    .m    (data),
    .cin  (c_flag),
    .y    (alu_y),
    .cout (alu_c),
    .z    (alu_z)
  );

  // Accumulator write-back: immediate ops in DECODE, memory ops in MEM
  always_comb begin
    alu_we = 1'b0;
    if (state == ST_DECODE && mode_i == AM_IMM) alu_we = 1'b1;
    if (state == ST_MEM && !is_sta)             alu_we = 1'b1;
  end

  // Sequencer: pc, bus address, write strobe and state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_FETCH;
      pc    <= RST_ADDR;
      addr  <= RST_ADDR;
      rw    <= 1'b0;
      instr <= '0;
`ifdef U14_ABS_EN
      lo_byte <= '0;
`endif
    end else begin
      case (state)
        ST_FETCH: begin
          instr <= data[7:0];
          pc    <= pc_inc;
          addr  <= pc_inc;
          state <= (mode_f == AM_NONE) ? ST_FETCH : ST_DECODE;
        end
        ST_DECODE: begin
          pc <= pc_inc;
          case (mode_i)
            AM_ZP: begin
              addr  <= AW'(data[7:0]);
              rw    <= is_sta;
              state <= ST_MEM;
            end
`ifdef U14_ABS_EN
            AM_ABS, AM_JMP: begin
              lo_byte <= data[7:0];
              addr    <= pc_inc;
              state   <= ST_OPHI;
            end
`endif
            default: begin
              addr  <= pc_inc;
              state <= ST_FETCH;
            end
          endcase
        end
`ifdef U14_ABS_EN
        ST_OPHI: begin
          if (mode_i == AM_JMP) begin
            pc    <= target;
            addr  <= target;
            state <= ST_FETCH;
          end else begin
            pc    <= pc_inc;
            addr  <= target;
            rw    <= is_sta;
            state <= ST_MEM;
          end
        end
`endif
        ST_MEM: begin
          rw    <= 1'b0;
          addr  <= pc;
          state <= ST_FETCH;
        end
        default: begin
          rw    <= 1'b0;
          addr  <= pc;
          state <= ST_FETCH;
        end
      endcase
    end
  end

  // Accumulator and flags; STA and JMP never assert alu_we
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc    <= '0;
      c_flag <= 1'b0;
      z_flag <= 1'b0;
    end else if (alu_we) begin
      acc    <= alu_y;
      c_flag <= alu_c;
      z_flag <= alu_z;
    end
  end

endmodule

// File: tb/tb_u14_cpu.sv
// tb_u14_cpu: table-driven immediate-op vectors, hand-written bus sequences
// and a randomized program run against an instruction-level reference model.
module tb_u14_cpu;

`ifdef U14_ABS_EN
  localparam bit ABS = 1'b1;
`else
  localparam bit ABS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  wire  [7:0]  data;
  logic [15:0] addr;
  logic        rw;
  logic        sync;
  logic [7:0]  acc;
  logic [1:0]  flags;

  logic [7:0]  mem     [0:65535];
  logic [7:0]  ref_mem [0:65535];

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [15:0] a;
    logic [7:0]  d;
  } wr_t;
  wr_t wr_q[$];

  // Model architectural state
  logic [15:0] m_pc;
  logic [7:0]  m_a;
  logic        m_c;
  logic        m_z;

  u14_cpu #(.DW(8), .AW(16), .RST_ADDR(16'hFFF0)) dut (
    .clk   (clk),
    .rst   (rst),
    .data  (data),
    .addr  (addr),
    .rw    (rw),
    .sync  (sync),
    .acc   (acc),
    .flags (flags)
  );

  always #5 clk = ~clk;

  // Combinational-read memory; captures the bus on a write cycle edge
  assign data = rw ? 8'hzz : mem[addr];

  always @(posedge clk) begin
    if (rw) begin
      mem[addr] = data;
      wr_q.push_back({addr, data});
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic fill_nop();
    for (int i = 0; i < 65536; i++) mem[i] = 8'hEA;
  endtask

  // Bytes are listed most-significant first: first byte lands at base
  task automatic load(input logic [15:0] base, input logic [63:0] bytes, input int n);
    logic [15:0] p;
    for (int i = 0; i < n; i++) begin
      p = base + 16'(i);
      mem[p] = bytes[63 - 8*i -: 8];
    end
  endtask

  // Execute one instruction from ref_mem at m_pc; returns its cycle count
  task automatic model_step(output int cyc, output bit st, output wr_t w);
    logic [7:0]  opc, op1, op2, m;
    logic [3:0]  hi, lo;
    logic [15:0] p1, p2, ea;
    int          s;
    bit          valid;
    p1  = m_pc + 16'd1;
    p2  = m_pc + 16'd2;
    opc = ref_mem[m_pc];
    op1 = ref_mem[p1];
    op2 = ref_mem[p2];
    hi  = opc[7:4];
    lo  = opc[3:0];
    st  = 1'b0;
    w   = '0;
    m   = 8'h00;
    valid = (hi inside {4'h0, 4'h2, 4'h4, 4'h6, 4'h8, 4'hA, 4'hE}) &&
            (lo == 4'h9 || lo == 4'h5 || (ABS && lo == 4'hD)) &&
            (opc != 8'h89);
    if (ABS && opc == 8'h4C) begin
      m_pc = {op2, op1};
      cyc  = 3;
      return;
    end
    if (!valid) begin
      m_pc = p1;
      cyc  = 1;
      return;
    end
    if (lo == 4'h9) begin
      m    = op1;
      m_pc = p2;
      cyc  = 2;
    end else begin
      if (lo == 4'h5) begin
        ea   = {8'h00, op1};
        m_pc = p2;
        cyc  = 3;
      end else begin
        ea   = {op2, op1};
        m_pc = m_pc + 16'd3;
        cyc  = 4;
      end
      if (hi == 4'h8) begin
        ref_mem[ea] = m_a;
        st = 1'b1;
        w  = {ea, m_a};
        return;
      end
      m = ref_mem[ea];
    end
    case (hi)
      4'h0: m_a = m_a | m;
      4'h2: m_a = m_a & m;
      4'h4: m_a = m_a ^ m;
      4'hA: m_a = m;
      4'h6: begin
        s   = int'(m_a) + int'(m) + int'(m_c);
        m_a = 8'(s);
        m_c = (s > 255);
      end
      default: begin
        s   = int'(m_a) + (255 - int'(m)) + int'(m_c);
        m_a = 8'(s);
        m_c = (s > 255);
      end
    endcase
    m_z = (m_a == 8'h00);
  endtask

  typedef struct packed {
    logic [7:0] opc;
    logic [7:0] a0;
    logic [7:0] m;
    logic       c0;
    logic [7:0] ea;
    logic       ec;
    logic       ez;
  } vec_t;

  vec_t tv [13];

  logic [7:0] op_list [23];

  initial begin
    int          cyc;
    bit          st;
    wr_t         w;
    int          e0;
    logic [7:0]  cb;

    tv[0]  = '{8'h69, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b1};
    tv[1]  = '{8'h69, 8'h7F, 8'h80, 1'b1, 8'h00, 1'b1, 1'b1};
    tv[2]  = '{8'h69, 8'h10, 8'h20, 1'b1, 8'h31, 1'b0, 1'b0};
    tv[3]  = '{8'hE9, 8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b1};
    tv[4]  = '{8'hE9, 8'h05, 8'h06, 1'b1, 8'hFF, 1'b0, 1'b0};
    tv[5]  = '{8'hE9, 8'h10, 8'h01, 1'b0, 8'h0E, 1'b1, 1'b0};
    tv[6]  = '{8'h29, 8'hF0, 8'h3C, 1'b1, 8'h30, 1'b1, 1'b0};
    tv[7]  = '{8'h29, 8'h0F, 8'hF0, 1'b0, 8'h00, 1'b0, 1'b1};
    tv[8]  = '{8'h09, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1};
    tv[9]  = '{8'h09, 8'hA0, 8'h05, 1'b1, 8'hA5, 1'b1, 1'b0};
    tv[10] = '{8'h49, 8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b1};
    tv[11] = '{8'h49, 8'h5A, 8'h0F, 1'b1, 8'h55, 1'b1, 1'b0};
    tv[12] = '{8'hA9, 8'h12, 8'h00, 1'b1, 8'h00, 1'b1, 1'b1};

    op_list = '{8'h09, 8'h05, 8'h0D, 8'h29, 8'h25, 8'h2D, 8'h49, 8'h45,
                8'h4D, 8'h69, 8'h65, 8'h6D, 8'h85, 8'h8D, 8'hA9, 8'hA5,
                8'hAD, 8'hE9, 8'hE5, 8'hED, 8'hEA, 8'h4C, 8'h89};

    // Reset values while rst is held
    fill_nop();
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("reset acc",   32'(acc),   32'h00);
    chk("reset flags", 32'(flags), 32'h0);
    chk("reset rw",    32'(rw),    32'h0);
    chk("reset addr",  32'(addr),  32'hFFF0);
    chk("reset sync",  32'(sync),  32'h1);

    // Immediate ALU vectors: set C, load A, apply op
    for (int i = 0; i < 13; i++) begin
      fill_nop();
      cb = tv[i].c0 ? 8'hFF : 8'h00;
      load(16'hFFF0, {8'hA9, cb, 8'h69, cb, 8'hA9, tv[i].a0, tv[i].opc, tv[i].m}, 8);
      do_reset();
      tick(8);
      chk($sformatf("vec%0d acc", i),   32'(acc),   32'(tv[i].ea));
      chk($sformatf("vec%0d flags", i), 32'(flags), 32'({tv[i].ec, tv[i].ez}));
      chk($sformatf("vec%0d addr", i),  32'(addr),  32'hFFF8);
    end

    // LDA #05; ADC #03
    fill_nop();
    load(16'hFFF0, {8'hA9, 8'h05, 8'h69, 8'h03, 32'h0}, 4);
    do_reset();
    tick(1);
    chk("imm decode sync", 32'(sync), 32'h0);
    tick(3);
    chk("lda adc state", 32'({acc, flags, addr}), 32'({8'h08, 2'b00, 16'hFFF4}));
    chk("lda adc sync",  32'(sync), 32'h1);

    // ADC #01 from FF wraps to zero, then SBC #00 with carry set
    fill_nop();
    load(16'hFFF0, {8'hA9, 8'hFF, 8'h69, 8'h01, 8'hE9, 8'h00, 16'h0}, 6);
    do_reset();
    tick(4);
    chk("adc wrap", 32'({acc, flags}), 32'({8'h00, 2'b11}));
    tick(2);
    chk("sbc zero", 32'({acc, flags}), 32'({8'h00, 2'b11}));

    // LDA #3C; STA $42: single write cycle
    fill_nop();
    mem[16'h0042] = 8'h00;
    load(16'hFFF0, {8'hA9, 8'h3C, 8'h85, 8'h42, 32'h0}, 4);
    do_reset();
    wr_q.delete();
    tick(3);
    chk("sta pre rw", 32'(rw), 32'h0);
    tick(1);
    chk("sta mem cycle", 32'({rw, addr, data}), 32'({1'b1, 16'h0042, 8'h3C}));
    tick(1);
    chk("sta after", 32'({rw, sync, addr}), 32'({1'b0, 1'b1, 16'hFFF4}));
    chk("sta stored", 32'(mem[16'h0042]), 32'h3C);
    tick(1);
    chk("sta write count", 32'(wr_q.size()), 32'd1);

    // Reset during the STA MEM cycle abandons the write
    fill_nop();
    mem[16'h0042] = 8'h00;
    load(16'hFFF0, {8'hA9, 8'h3C, 8'h85, 8'h42, 32'h0}, 4);
    do_reset();
    tick(4);
    chk("mid sta rw", 32'(rw), 32'h1);
    wr_q.delete();
    mem[16'hFFF0] = 8'hEA;
    #2;
    rst = 1'b1;
    #1;
    chk("async rst bus", 32'({rw, sync, addr, acc}), 32'({1'b0, 1'b1, 16'hFFF0, 8'h00}));
    chk("async rst data released", 32'(data), 32'hEA);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abandoned write", 32'({wr_q.size(), mem[16'h0042]}), 32'h0);
    tick(1);
    chk("nop after rst", 32'({sync, addr}), 32'({1'b1, 16'hFFF1}));

    // JMP $1234
    fill_nop();
    load(16'hFFF0, {8'h4C, 8'h34, 8'h12, 40'h0}, 3);
    do_reset();
`ifdef U14_ABS_EN
    tick(2);
    chk("jmp mid sync", 32'(sync), 32'h0);
    tick(1);
    chk("jmp target", 32'({sync, addr}), 32'({1'b1, 16'h1234}));
`else
    tick(1);
    chk("jmp as nop", 32'({sync, addr}), 32'({1'b1, 16'hFFF1}));
    tick(2);
    chk("jmp operands as nop", 32'(addr), 32'hFFF3);
`endif

    // LDA $1234; STA $0200
    fill_nop();
    mem[16'h1234] = 8'h77;
    mem[16'h0200] = 8'h00;
    load(16'hFFF0, {8'hAD, 8'h34, 8'h12, 8'h8D, 8'h00, 8'h02, 16'h0}, 6);
    do_reset();
`ifdef U14_ABS_EN
    tick(4);
    chk("lda abs", 32'({sync, addr, acc}), 32'({1'b1, 16'hFFF3, 8'h77}));
    tick(3);
    chk("sta abs cycle", 32'({rw, addr}), 32'({1'b1, 16'h0200}));
    tick(1);
    chk("sta abs after", 32'({rw, addr, mem[16'h0200]}), 32'({1'b0, 16'hFFF6, 8'h77}));
`else
    tick(1);
    chk("lda abs as nop", 32'({sync, addr, acc}), 32'({1'b1, 16'hFFF1, 8'h00}));
`endif

    // pc wraps past FFFF
    fill_nop();
    do_reset();
    tick(16);
    chk("pc wrap", 32'(addr), 32'h0000);
    tick(1);
    chk("pc after wrap", 32'(addr), 32'h0001);

    // Randomized program against the reference model
    for (int i = 0; i < 65536; i++) begin
      cb = ($urandom_range(0, 9) < 7) ? op_list[$urandom_range(0, 22)] : 8'($urandom);
      mem[i]     = cb;
      ref_mem[i] = cb;
    end
    do_reset();
    wr_q.delete();
    m_pc = 16'hFFF0;
    m_a  = 8'h00;
    m_c  = 1'b0;
    m_z  = 1'b0;
    e0   = errors;
    for (int k = 0; k < 400; k++) begin
      model_step(cyc, st, w);
      tick(cyc);
      chk($sformatf("rand%0d state", k), 32'({sync, addr, acc, flags}),
          32'({1'b1, m_pc, m_a, m_c, m_z}));
      if (st) chk($sformatf("rand%0d store", k), 32'({wr_q.size() == 1, (wr_q.size() > 0) ? wr_q[0] : 24'h0}),
                  32'({1'b1, w}));
      else    chk($sformatf("rand%0d no store", k), 32'(wr_q.size()), 32'd0);
      wr_q.delete();
      if (errors > e0) break;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
